// File: rtl/uart_receiver.sv
// UART receive path: synchronizes rx, mid-bit samples a start/data/stop frame
// and presents each byte on a valid/ready handshake with framing-error and overrun status.
module uart_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic [15:0] clocksPerCycle,
    input  logic [3:0]  bitsPerFrame,
    input  logic        rxDataReady,
    output logic [7:0]  rxData,
    output logic        rxDataValid,
    output logic        rxFrameError,
    output logic        rxOverrun,
    output logic        rxBusy
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_prev_reg;
    logic [15:0]            count_reg;
    logic [3:0]             bit_count_reg;
    logic [7:0]             shift_reg;

    logic                   rxs;
    logic                   cycle_done;
    logic                   half_done;
    logic                   bits_done;
    logic [2:0]             bit_index;
    logic [7:0]             frame_mask;

    assign rxs        = sync_reg[SYNC_STAGES-1];
    assign cycle_done = (count_reg >= clocksPerCycle);
    assign half_done  = (count_reg >= (clocksPerCycle >> 1));
    assign bits_done  = (bit_count_reg >= bitsPerFrame);
    assign bit_index  = 3'(bit_count_reg - 4'd1);

    // Only the low bitsPerFrame bits of a delivered byte carry data.
    for (genvar gi = 0; gi < 8; gi++) begin : g_mask
        assign frame_mask[gi] = (bitsPerFrame > 4'(gi));
    end

    // Synchronizer resets to the idle level so reset release never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg    <= '1;
            rx_prev_reg <= 1'b1;
        end else begin
            sync_reg    <= {sync_reg[SYNC_STAGES-2:0], rx};
            rx_prev_reg <= rxs;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= 16'd1;
            bit_count_reg <= 4'd1;
            shift_reg     <= 8'h00;
            rxData        <= 8'h00;
            rxDataValid   <= 1'b0;
            rxFrameError  <= 1'b0;
            rxOverrun     <= 1'b0;
            rxBusy        <= 1'b0;
        end else begin
            // A consume clears status; a load later in this block takes precedence.
            if (rxDataValid && rxDataReady) begin
                rxDataValid  <= 1'b0;
                rxFrameError <= 1'b0;
                rxOverrun    <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    count_reg     <= 16'd1;
                    bit_count_reg <= 4'd1;
                    if (rx_prev_reg && !rxs) begin
                        state_reg <= START;
                        rxBusy    <= 1'b1;
                    end
                end

                START: begin
                    if (half_done) begin
                        count_reg <= 16'd1;
                        if (!rxs) begin
                            state_reg <= DATA;
                        end else begin
                            state_reg <= IDLE;
                            rxBusy    <= 1'b0;
                        end
                    end else begin
                        count_reg <= count_reg + 16'd1;
                    end
                end

                DATA: begin
                    if (cycle_done) begin
                        count_reg <= 16'd1;
                        if (bit_count_reg <= 4'd8) begin
                            shift_reg[bit_index] <= rxs;
                        end
                        if (bits_done) begin
                            state_reg     <= STOP;
                            bit_count_reg <= 4'd1;
                        end else begin
                            bit_count_reg <= bit_count_reg + 4'd1;
                        end
                    end else begin
                        count_reg <= count_reg + 16'd1;
                    end
                end

                STOP: begin
                    if (cycle_done) begin
                        // Leave at mid-stop-bit so a back-to-back start edge is not missed.
                        state_reg    <= IDLE;
                        rxBusy       <= 1'b0;
                        count_reg    <= 16'd1;
                        rxData       <= shift_reg & frame_mask;
                        rxFrameError <= !rxs;
                        rxDataValid  <= 1'b1;
                        rxOverrun    <= rxDataValid && !rxDataReady;
                        shift_reg    <= 8'h00;
                    end else begin
                        count_reg <= count_reg + 16'd1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    rxBusy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table-driven frames, hand-timed corner
// sequences and randomized frames scored against a queue-based frame model.
module tb_uart_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic [15:0] clocksPerCycle;
    logic [3:0]  bitsPerFrame;
    logic        rxDataReady;
    logic [7:0]  rxData;
    logic        rxDataValid;
    logic        rxFrameError;
    logic        rxOverrun;
    logic        rxBusy;

    uart_receiver #(.SYNC_STAGES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx             (rx),
        .clocksPerCycle (clocksPerCycle),
        .bitsPerFrame   (bitsPerFrame),
        .rxDataReady    (rxDataReady),
        .rxData         (rxData),
        .rxDataValid    (rxDataValid),
        .rxFrameError   (rxFrameError),
        .rxOverrun      (rxOverrun),
        .rxBusy         (rxBusy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       ovr;
    } frame_t;

    typedef struct {
        logic [7:0] data;
        int         n;
        int         c;
        logic       stopb;
        logic [7:0] exp_data;
        logic       exp_fe;
    } vec_t;

    int     checks = 0;
    int     errors = 0;
    int     frames_seen = 0;
    frame_t exp_q[$];
    vec_t   vecs[9];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs are read at the falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic frame_t mk(input logic [7:0] d, input logic fe, input logic ovr);
        frame_t f;
        f.data = d;
        f.fe   = fe;
        f.ovr  = ovr;
        return f;
    endfunction

    // Expected delivery of an n-bit frame: value modulo 2^n, error when stop bit is low.
    function automatic frame_t model(input logic [7:0] d, input int n, input logic stopb);
        return mk(8'(int'(d) % (1 << n)), !stopb, 1'b0);
    endfunction

    // Line driver: idle high, start, n data bits LSB first, stop; leaves rx at the stop level.
    task automatic send(input logic [7:0] d, input int n, input int c, input logic stopb, input int idle);
        tick(1);
        rx = 1'b1;
        tick(idle);
        rx = 1'b0;
        tick(c);
        for (int k = 0; k < n; k++) begin
            rx = d[k];
            tick(c);
        end
        rx = stopb;
        tick(c);
        $display("sent data=%02h bits=%0d cpc=%0d stop=%0b", d, n, c, stopb);
    endtask

    task automatic consume(input string name);
        tick(1);
        rxDataReady = 1'b1;
        tick(1);
        rxDataReady = 1'b0;
        smp();
        chk({name, "_valid_clr"}, rxDataValid, 1'b0);
        chk({name, "_fe_clr"}, rxFrameError, 1'b0);
        chk({name, "_ovr_clr"}, rxOverrun, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!reset && rxDataValid && rxDataReady) begin : mon
            frame_t e;
            frames_seen++;
            $display("frame data=%02h fe=%0b ovr=%0b", rxData, rxFrameError, rxOverrun);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame actual=%02h required=none", rxData);
            end else begin
                e = exp_q.pop_front();
                chk("mon_data", rxData, e.data);
                chk("mon_fe", rxFrameError, e.fe);
                chk("mon_ovr", rxOverrun, e.ovr);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int fs;
        logic [7:0] d;
        int c;
        int n;
        logic sb;

        vecs[0] = '{8'hA5, 8, 16, 1'b1, 8'hA5, 1'b0};
        vecs[1] = '{8'h3B, 5, 10, 1'b1, 8'h1B, 1'b0};
        vecs[2] = '{8'hFF, 8, 16, 1'b0, 8'hFF, 1'b1};
        vecs[3] = '{8'h5A, 8, 16, 1'b1, 8'h5A, 1'b0};
        vecs[4] = '{8'hC3, 4, 8,  1'b1, 8'h03, 1'b0};
        vecs[5] = '{8'h80, 7, 12, 1'b1, 8'h00, 1'b0};
        vecs[6] = '{8'h01, 1, 4,  1'b1, 8'h01, 1'b0};
        vecs[7] = '{8'h6D, 6, 9,  1'b0, 8'h2D, 1'b1};
        vecs[8] = '{8'hFE, 8, 4,  1'b1, 8'hFE, 1'b0};

        reset = 1'b1;
        rx = 1'b1;
        rxDataReady = 1'b0;
        clocksPerCycle = 16'd16;
        bitsPerFrame = 4'd8;
        tick(3);
        smp();
        chk("rst_data", rxData, 8'h00);
        chk("rst_valid", rxDataValid, 1'b0);
        chk("rst_fe", rxFrameError, 1'b0);
        chk("rst_ovr", rxOverrun, 1'b0);
        chk("rst_busy", rxBusy, 1'b0);
        tick(1);
        reset = 1'b0;
        tick(4);
        smp();
        chk("idle_busy", rxBusy, 1'b0);

        // Exact latency of the first 8N1 frame: valid rises at E+H+(N+1)*C+1, E = start+2.
        fork
            send(8'hA5, 8, 16, 1'b1, 0);
            begin
                tick(1);
                tick(154);
                smp();
                chk("t1_valid_early", rxDataValid, 1'b0);
                tick(1);
                smp();
                chk("t1_valid_rise", rxDataValid, 1'b1);
                chk("t1_data", rxData, 8'hA5);
            end
        join
        tick(5);
        smp();
        chk("t1_hold_valid", rxDataValid, 1'b1);
        chk("t1_hold_data", rxData, 8'hA5);
        chk("t1_hold_fe", rxFrameError, 1'b0);
        chk("t1_hold_ovr", rxOverrun, 1'b0);
        exp_q.push_back(mk(8'hA5, 1'b0, 1'b0));
        consume("t1");

        for (int i = 0; i < 9; i++) begin
            clocksPerCycle = 16'(vecs[i].c);
            bitsPerFrame = 4'(vecs[i].n);
            send(vecs[i].data, vecs[i].n, vecs[i].c, vecs[i].stopb, 6);
            tick(16);
            smp();
            chk("vec_valid", rxDataValid, 1'b1);
            chk("vec_data", rxData, vecs[i].exp_data);
            chk("vec_fe", rxFrameError, vecs[i].exp_fe);
            chk("vec_ovr", rxOverrun, 1'b0);
            chk("vec_busy", rxBusy, 1'b0);
            exp_q.push_back(mk(vecs[i].exp_data, vecs[i].exp_fe, 1'b0));
            consume("vec");
        end

        // Loopback-style: 5-bit frame, then 16 back-to-back random bytes with ready held high.
        tick(1);
        rxDataReady = 1'b1;
        clocksPerCycle = 16'd10;
        bitsPerFrame = 4'd5;
        exp_q.push_back(model(8'h3B, 5, 1'b1));
        send(8'h3B, 5, 10, 1'b1, 4);
        tick(16);
        bitsPerFrame = 4'd8;
        fs = frames_seen;
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            exp_q.push_back(model(d, 8, 1'b1));
            send(d, 8, 10, 1'b1, 0);
        end
        tick(16);
        smp();
        chk("b2b_count", 16'(frames_seen - fs), 16'd16);
        chk("b2b_pending", 16'(exp_q.size()), 16'd0);

        // Random configuration, data and stop level per frame.
        for (int i = 0; i < 20; i++) begin
            c = int'($urandom_range(4, 24));
            n = int'($urandom_range(1, 8));
            d = 8'($urandom);
            sb = ($urandom_range(0, 3) != 0);
            clocksPerCycle = 16'(c);
            bitsPerFrame = 4'(n);
            exp_q.push_back(model(d, n, sb));
            send(d, n, c, sb, 6);
            tick(16);
        end
        smp();
        chk("rand_pending", 16'(exp_q.size()), 16'd0);

        // False start: 4-clock low glitch.
        clocksPerCycle = 16'd16;
        bitsPerFrame = 4'd8;
        fs = frames_seen;
        tick(1);
        rx = 1'b1;
        tick(4);
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        smp();
        chk("fs_busy_high", rxBusy, 1'b1);
        tick(8);
        smp();
        chk("fs_busy_low", rxBusy, 1'b0);
        tick(20);
        smp();
        chk("fs_no_frame", 16'(frames_seen - fs), 16'd0);
        exp_q.push_back(model(8'h5A, 8, 1'b1));
        send(8'h5A, 8, 16, 1'b1, 4);
        tick(16);
        smp();
        chk("fs_next_frame", 16'(frames_seen - fs), 16'd1);

        // Framing error followed by a long low line: only one further frame.
        fs = frames_seen;
        exp_q.push_back(model(8'hFF, 8, 1'b0));
        send(8'hFF, 8, 16, 1'b0, 4);
        tick(50);
        smp();
        chk("fe_low_busy", rxBusy, 1'b0);
        tick(50);
        exp_q.push_back(model(8'h01, 8, 1'b1));
        send(8'h01, 8, 16, 1'b1, 6);
        tick(16);
        smp();
        chk("fe_count", 16'(frames_seen - fs), 16'd2);
        chk("fe_pending", 16'(exp_q.size()), 16'd0);

        // Overrun: second frame lands on an unconsumed first.
        tick(1);
        rxDataReady = 1'b0;
        send(8'h11, 8, 16, 1'b1, 4);
        send(8'h22, 8, 16, 1'b1, 0);
        tick(16);
        smp();
        chk("ovr_valid", rxDataValid, 1'b1);
        chk("ovr_data", rxData, 8'h22);
        chk("ovr_flag", rxOverrun, 1'b1);
        chk("ovr_fe", rxFrameError, 1'b0);
        exp_q.push_back(mk(8'h22, 1'b0, 1'b1));
        consume("ovr");

        // Consume exactly in the load cycle of the next frame: no overrun.
        send(8'h33, 8, 16, 1'b1, 4);
        tick(16);
        smp();
        chk("lc_first_valid", rxDataValid, 1'b1);
        chk("lc_first_data", rxData, 8'h33);
        exp_q.push_back(mk(8'h33, 1'b0, 1'b0));
        fork
            send(8'h44, 8, 16, 1'b1, 0);
            begin
                tick(1);
                tick(154);
                rxDataReady = 1'b1;
                tick(1);
                rxDataReady = 1'b0;
                smp();
                chk("lc_valid", rxDataValid, 1'b1);
                chk("lc_data", rxData, 8'h44);
                chk("lc_ovr", rxOverrun, 1'b0);
            end
        join
        exp_q.push_back(mk(8'h44, 1'b0, 1'b0));
        consume("lc");

        // Reset in the middle of data bit 3 with a frame still presented.
        send(8'h96, 8, 16, 1'b1, 4);
        tick(16);
        smp();
        chk("rm_pre_valid", rxDataValid, 1'b1);
        chk("rm_pre_data", rxData, 8'h96);
        fork
            send(8'hC3, 8, 16, 1'b1, 4);
            begin
                tick(5);
                tick(4 * 16 + 8);
                chk("rm_busy_before", rxBusy, 1'b1);
                reset = 1'b1;
                smp();
                chk("rm_data", rxData, 8'h00);
                chk("rm_valid", rxDataValid, 1'b0);
                chk("rm_fe", rxFrameError, 1'b0);
                chk("rm_ovr", rxOverrun, 1'b0);
                chk("rm_busy", rxBusy, 1'b0);
            end
        join
        tick(4);
        reset = 1'b0;
        tick(4);
        smp();
        chk("rm_after_busy", rxBusy, 1'b0);
        chk("rm_after_valid", rxDataValid, 1'b0);
        tick(1);
        rxDataReady = 1'b1;
        fs = frames_seen;
        exp_q.push_back(model(8'h3C, 8, 1'b1));
        send(8'h3C, 8, 16, 1'b1, 4);
        tick(16);
        smp();
        chk("rm_next_count", 16'(frames_seen - fs), 16'd1);
        chk("final_pending", 16'(exp_q.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
